// File: rtl/hist_eq_param_ctrl.sv
// Staged histogram-equalizer parameters, committed to the active set only at frame boundaries.
// Optional start-of-frame counter enabled by defining HIST_EQ_CTRL_FRAME_CNT_EN.
module hist_eq_param_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEF_UPPER    = 717,
   parameter int DEF_LOWER    = 205,
   parameter int DEF_THRESH   = 128,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_areset,
   input  logic                  cfg_wr_en,
   input  logic [1:0]            cfg_wr_addr,
   input  logic [15:0]           cfg_wr_data,
   output logic                  cfg_wr_ack,
   input  logic                  mon_tvalid,
   input  logic                  mon_tuser,
   input  logic                  mon_tready,
   output logic [DATA_WIDTH-1:0] contrast_threshold_param,
   output logic [9:0]            upper_bound_param,
   output logic [9:0]            lower_bound_param,
   output logic                  thresholding_en,
   output logic                  commit_done,
   output logic                  cfg_error,
   output logic [1:0]            ctrl_state,
   output logic [15:0]           frame_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, PENDING = 2'd2} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] thresh;
      logic [9:0]            upper;
      logic [9:0]            lower;
      logic                  en;
   } param_t;

   localparam param_t DEF_SET = '{thresh: DATA_WIDTH'(DEF_THRESH), upper: 10'(DEF_UPPER),
                                  lower: 10'(DEF_LOWER), en: 1'b0};
   localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(IDLE_TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

   state_t          state, state_nxt;
   param_t          stg, act, load_set;
   logic [TO_W-1:0] idle_cnt;
   logic            sof, wr_ctrl, commit_req, stg_valid, timeout_hit, load, reject;

   assign sof         = mon_tvalid & mon_tready & mon_tuser;
   assign wr_ctrl     = cfg_wr_en && (cfg_wr_addr == 2'd3);
   assign commit_req  = wr_ctrl && cfg_wr_data[1];
   assign stg_valid   = stg.lower < stg.upper;
   // The idle cycle that brings the run length to IDLE_TIMEOUT is the one that fires.
   assign timeout_hit = !mon_tvalid && (idle_cnt >= TO_LAST);

   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      reject    = 1'b0;
      load_set  = stg;
      case (state)
         IDLE: begin
            // No frame in flight: commit immediately, with the enable bit from this same write.
            if (commit_req) begin
               if (stg_valid) begin
                  load        = 1'b1;
                  load_set.en = cfg_wr_data[0];
               end else begin
                  reject = 1'b1;
               end
            end
            if (sof) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (commit_req) begin
               if (stg_valid) state_nxt = PENDING;
               else           reject    = 1'b1;
            end
         end
         PENDING: begin
            // Staging may have changed while waiting, so the set is re-checked when it lands.
            if (sof || timeout_hit) begin
               if (stg_valid) load   = 1'b1;
               else           reject = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) begin
         stg         <= DEF_SET;
         act         <= DEF_SET;
         idle_cnt    <= '0;
         cfg_wr_ack  <= 1'b0;
         commit_done <= 1'b0;
         cfg_error   <= 1'b0;
      end else begin
         cfg_wr_ack  <= cfg_wr_en;
         commit_done <= load;
         if (load) act <= load_set;
         if (cfg_wr_en) begin
            case (cfg_wr_addr)
               2'd0: stg.thresh <= cfg_wr_data[DATA_WIDTH-1:0];
               2'd1: stg.upper  <= cfg_wr_data[9:0];
               2'd2: stg.lower  <= cfg_wr_data[9:0];
               2'd3: stg.en     <= cfg_wr_data[0];
               default: ;
            endcase
         end
         if (reject)                       cfg_error <= 1'b1;
         else if (wr_ctrl && cfg_wr_data[2]) cfg_error <= 1'b0;
         if (mon_tvalid)            idle_cnt <= '0;
         else if (idle_cnt < TO_MAX) idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign contrast_threshold_param = act.thresh;
   assign upper_bound_param        = act.upper;
   assign lower_bound_param        = act.lower;
   assign thresholding_en          = act.en;
   assign ctrl_state               = state;

`ifdef HIST_EQ_CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;
   logic        unused_data;

   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset)                    frame_cnt_q <= '0;
      else if (wr_ctrl && cfg_wr_data[3])  frame_cnt_q <= '0;
      else if (sof)                        frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_cnt   = frame_cnt_q;
   assign unused_data = ^cfg_wr_data[15:10];
`else
   logic unused_data;

   assign frame_cnt   = '0;
   assign unused_data = ^{cfg_wr_data[15:10], cfg_wr_data[3]};
`endif

endmodule

// File: tb/tb_hist_eq_param_ctrl.sv
// Scoreboard bench for hist_eq_param_ctrl: a rule-level model predicts each cycle's outputs
// and every committed parameter set; a separate monitor pops and compares.
module tb_hist_eq_param_ctrl;
   localparam int IDLE_TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_wr_en = 1'b0;
   logic [1:0]  cfg_wr_addr = '0;
   logic [15:0] cfg_wr_data = '0;
   logic        mon_tvalid = 1'b0, mon_tuser = 1'b0, mon_tready = 1'b0;
   logic        cfg_wr_ack, thresholding_en, commit_done, cfg_error;
   logic [7:0]  contrast_threshold_param;
   logic [9:0]  upper_bound_param, lower_bound_param;
   logic [1:0]  ctrl_state;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   hist_eq_param_ctrl #(.DATA_WIDTH(8), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
      .i_sys_clk(clk), .i_sys_areset(rst),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .cfg_wr_ack(cfg_wr_ack),
      .mon_tvalid(mon_tvalid), .mon_tuser(mon_tuser), .mon_tready(mon_tready),
      .contrast_threshold_param(contrast_threshold_param),
      .upper_bound_param(upper_bound_param), .lower_bound_param(lower_bound_param),
      .thresholding_en(thresholding_en), .commit_done(commit_done), .cfg_error(cfg_error),
      .ctrl_state(ctrl_state), .frame_cnt(frame_cnt)
   );

   typedef struct packed {
      logic [7:0] thr;
      logic [9:0] up;
      logic [9:0] lo;
      logic       en;
   } pset_t;

   typedef struct packed {
      logic [1:0]  st;
      logic        err;
      logic        ack;
      logic        done;
      pset_t       act;
      logic [15:0] fc;
   } snap_t;

   snap_t exp_q[$];
   pset_t cmt_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // model state: what the spec says has happened so far
   pset_t m_stg, m_act;
   bit    m_seen_sof, m_pending, m_err;
   int    m_idle_run, m_fc;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_stg      = '{thr: 8'd128, up: 10'd717, lo: 10'd205, en: 1'b0};
      m_act      = m_stg;
      m_seen_sof = 0;
      m_pending  = 0;
      m_err      = 0;
      m_idle_run = 0;
      m_fc       = 0;
   endfunction

   task automatic step(input bit r, input bit we, input bit [1:0] a, input bit [15:0] d,
                       input bit tv, input bit tu, input bit tr);
      snap_t s;
      pset_t src;
      bit sof, wctl, commit, valid, apply, reject;
      @(negedge clk);
      rst = r; cfg_wr_en = we; cfg_wr_addr = a; cfg_wr_data = d;
      mon_tvalid = tv; mon_tuser = tu; mon_tready = tr;
      apply = 0; reject = 0;
      if (r) begin
         model_reset();
      end else begin
         sof    = tv && tu && tr;
         wctl   = we && (a == 2'd3);
         commit = wctl && d[1];
         valid  = m_stg.lo < m_stg.up;
         src    = m_stg;
         m_idle_run = tv ? 0 : m_idle_run + 1;
         if (!m_seen_sof) begin
            if (commit) begin
               if (valid) begin apply = 1; src.en = d[0]; end
               else reject = 1;
            end
            if (sof) m_seen_sof = 1;
         end else if (!m_pending) begin
            if (commit) begin
               if (valid) m_pending = 1;
               else reject = 1;
            end
         end else if (sof || m_idle_run >= IDLE_TIMEOUT) begin
            if (valid) apply = 1;
            else reject = 1;
            m_pending = 0;
         end
         if (apply) begin
            m_act = src;
            cmt_q.push_back(src);
         end
         if (we) begin
            case (a)
               2'd0: m_stg.thr = d[7:0];
               2'd1: m_stg.up  = d[9:0];
               2'd2: m_stg.lo  = d[9:0];
               default: m_stg.en = d[0];
            endcase
         end
         if (reject) m_err = 1;
         else if (wctl && d[2]) m_err = 0;
`ifdef HIST_EQ_CTRL_FRAME_CNT_EN
         if (wctl && d[3]) m_fc = 0;
         else if (sof) m_fc = (m_fc + 1) % 65536;
`endif
      end
      s.st   = !m_seen_sof ? 2'd0 : (m_pending ? 2'd2 : 2'd1);
      s.err  = m_err;
      s.ack  = we && !r;
      s.done = apply;
      s.act  = m_act;
      s.fc   = 16'(m_fc);
      exp_q.push_back(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 2'd0, 16'd0, 1'($urandom), 1'b0, 1'($urandom));
   endtask

   task automatic wr(input bit [1:0] a, input bit [15:0] d);
      step(0, 1, a, d, 1'($urandom), 1'b0, 1'($urandom));
   endtask

   task automatic sof();
      step(0, 0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic driver();
      wr(2'd1, 16'd600); wr(2'd2, 16'd100); wr(2'd3, 16'h0002); idle(3);
      sof(); idle(2);
      wr(2'd0, 16'd60); wr(2'd3, 16'h0002); idle(5); sof(); idle(2);
      wr(2'd2, 16'd800); wr(2'd1, 16'd700); wr(2'd3, 16'h0002); idle(2);
      wr(2'd3, 16'h0004); idle(2);
      wr(2'd2, 16'd100); wr(2'd3, 16'h0002);
      for (int i = 0; i < IDLE_TIMEOUT + 6; i++) step(0, 0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      idle(2);
      wr(2'd3, 16'h0002); wr(2'd3, 16'h0002); wr(2'd0, 16'd90);
      step(0, 1, 2'd0, 16'd77, 1'b1, 1'b1, 1'b1); idle(2);
      wr(2'd3, 16'h0002); idle(2);
      step(1, 0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0); idle(2);
      wr(2'd3, 16'h0003); idle(2);
      for (int i = 0; i < 400; i++) begin
         step(0, $urandom_range(0, 2) == 0, 2'($urandom), 16'($urandom),
              1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0, 1'($urandom));
      end
`ifdef HIST_EQ_CTRL_FRAME_CNT_EN
      wr(2'd3, 16'h0008); idle(1);
      repeat (3) sof();
      idle(2);
      repeat (65533) sof();
      idle(2);
`endif
   endtask

   task automatic monitor();
      snap_t e;
      pset_t p;
      @(negedge clk);
      forever begin
         @(posedge clk); #2;
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL exp_underrun: got empty queue, expected a snapshot");
         end else begin
            e = exp_q.pop_front();
            chk("ctrl_state", 32'(ctrl_state), 32'(e.st));
            chk("cfg_error", 32'(cfg_error), 32'(e.err));
            chk("cfg_wr_ack", 32'(cfg_wr_ack), 32'(e.ack));
            chk("commit_done", 32'(commit_done), 32'(e.done));
            chk("thresh", 32'(contrast_threshold_param), 32'(e.act.thr));
            chk("upper", 32'(upper_bound_param), 32'(e.act.up));
            chk("lower", 32'(lower_bound_param), 32'(e.act.lo));
            chk("th_en", 32'(thresholding_en), 32'(e.act.en));
            chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
         end
         if (commit_done) begin
            if (cmt_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL commit_underrun: got commit_done, expected no commit");
            end else begin
               p = cmt_q.pop_front();
               chk("commit_set", 32'({contrast_threshold_param, upper_bound_param,
                                      lower_bound_param, thresholding_en}), 32'(p));
            end
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_thresh", 32'(contrast_threshold_param), 32'd128);
      chk("rst_upper", 32'(upper_bound_param), 32'd717);
      chk("rst_lower", 32'(lower_bound_param), 32'd205);
      chk("rst_en", 32'(thresholding_en), 32'd0);
      chk("rst_state", 32'(ctrl_state), 32'd0);
      chk("rst_error", 32'(cfg_error), 32'd0);
      chk("rst_done", 32'(commit_done), 32'd0);
      chk("rst_frame", 32'(frame_cnt), 32'd0);
      #1 rst = 1'b0;
      fork
         driver();
         monitor();
      join_any
      @(posedge clk); #3;
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("cmt_q_drained", 32'(cmt_q.size()), 32'd0);
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
